// File: rtl/chip_emu_pkg.sv
// Shared types and constants for the 74195 pin-level emulator.
// Pure definitions; no timing or flow control.
package chip_emu_pkg;

  typedef enum logic [1:0] {
    F_OFF    = 2'd0,
    F_ARMED  = 2'd1,
    F_ACTIVE = 2'd2
  } fault_state_t;

  // FaultPin encodings, lowest pin number first
  localparam logic [2:0] FAULT_PIN_11 = 3'd0;
  localparam logic [2:0] FAULT_PIN_12 = 3'd1;
  localparam logic [2:0] FAULT_PIN_13 = 3'd2;
  localparam logic [2:0] FAULT_PIN_14 = 3'd3;
  localparam logic [2:0] FAULT_PIN_15 = 3'd4;

  localparam logic [1:0] JK_CLEAR  = 2'b00;
  localparam logic [1:0] JK_HOLD   = 2'b01;
  localparam logic [1:0] JK_TOGGLE = 2'b10;
  localparam logic [1:0] JK_SET    = 2'b11;

  localparam int LANE_CLR_N   = 0;
  localparam int LANE_J       = 1;
  localparam int LANE_K_N     = 2;
  localparam int LANE_A       = 3;
  localparam int LANE_B       = 4;
  localparam int LANE_C       = 5;
  localparam int LANE_D       = 6;
  localparam int LANE_SH_LD_N = 7;
  localparam int LANE_CLK     = 8;
  localparam int NUM_LANES    = 9;

  function automatic logic jk_next_qa(input logic [1:0] jk, input logic qa);
    logic r;
    r = qa;
    case (jk)
      JK_CLEAR:  r = 1'b0;
      JK_SET:    r = 1'b1;
      JK_TOGGLE: r = ~qa;
      JK_HOLD:   r = qa;
      default:   r = qa;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chip_74195_emulator_pin_sync.sv
// Multi-flop pin synchronizer with optional registered rising-edge detect.
// Latency SYNC_STAGES cycles to q; rise is combinational on q; no backpressure.
module pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RISE_EN     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

  generate
    if (RISE_EN) begin : g_rise
      logic prev_q;
      logic prev_d;

      always_comb begin
        prev_d = q;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= prev_d;
        end
      end

      assign rise = q & ~prev_q;
    end else begin : g_no_rise
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/chip_74195_emulator.sv
// 74195 shift register emulated from the pin side, with stuck-at fault injection.
// Pin10 rise to Q pins in SYNC_STAGES+1 cycles; pin-level block, no backpressure.
module chip_74195_emulator
  import chip_emu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Pin1,
  input  logic       Pin2,
  input  logic       Pin3,
  input  logic       Pin4,
  input  logic       Pin5,
  input  logic       Pin6,
  input  logic       Pin7,
  input  logic       Pin9,
  input  logic       Pin10,
  output logic       Pin15,
  output logic       Pin14,
  output logic       Pin13,
  output logic       Pin12,
  output logic       Pin11,
  input  logic       FaultEn,
  input  logic [2:0] FaultPin,
  input  logic       FaultVal,
  input  logic [7:0] FaultDelay,
  output logic       FaultActive,
  output logic [7:0] EdgeCount
);

  localparam int                GATE_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [GATE_W-1:0] GATE_OPEN = GATE_W'(SYNC_STAGES + 1);

  logic [NUM_LANES-1:0] pin_raw;
  logic [NUM_LANES-1:0] pin_s;
  logic [NUM_LANES-1:0] lane_rise;

  assign pin_raw[LANE_CLR_N]   = Pin1;
  assign pin_raw[LANE_J]       = Pin2;
  assign pin_raw[LANE_K_N]     = Pin3;
  assign pin_raw[LANE_A]       = Pin4;
  assign pin_raw[LANE_B]       = Pin5;
  assign pin_raw[LANE_C]       = Pin6;
  assign pin_raw[LANE_D]       = Pin7;
  assign pin_raw[LANE_SH_LD_N] = Pin9;
  assign pin_raw[LANE_CLK]     = Pin10;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_sync
    pin_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .RISE_EN    (i == LANE_CLK)
    ) u_sync (
      .clk  (Clk),
      .reset(Reset),
      .d    (pin_raw[i]),
      .q    (pin_s[i]),
      .rise (lane_rise[i])
    );
  end

  logic [GATE_W-1:0] gate_q, gate_d;
  logic [3:0]        q_q, q_d;
  logic [7:0]        edge_cnt_q, edge_cnt_d;
  logic [7:0]        fcnt_q, fcnt_d;
  fault_state_t      state_q, state_d;
  logic              rise_det;
  logic [4:0]        pins_out;

  // Only the chip-CLK lane drives rise; the gate hides the post-reset fill of the chain.
  assign rise_det = (gate_q == GATE_OPEN) & pin_s[LANE_CLK] & (|lane_rise);

  always_comb begin
    gate_d = (gate_q == GATE_OPEN) ? gate_q : gate_q + GATE_W'(1);

    edge_cnt_d = rise_det ? edge_cnt_q + 8'd1 : edge_cnt_q;

    q_d = q_q;
    if (!pin_s[LANE_CLR_N]) begin
      q_d = 4'b0000;
    end else if (rise_det) begin
      if (!pin_s[LANE_SH_LD_N]) begin
        q_d = {pin_s[LANE_A], pin_s[LANE_B], pin_s[LANE_C], pin_s[LANE_D]};
      end else begin
        q_d = {jk_next_qa({pin_s[LANE_J], pin_s[LANE_K_N]}, q_q[3]), q_q[3:1]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      F_OFF: begin
        if (FaultEn) begin
          state_d = F_ARMED;
          fcnt_d  = FaultDelay;
        end
      end
      F_ARMED: begin
        if (!FaultEn) begin
          state_d = F_OFF;
        end else if (fcnt_q == 8'd0) begin
          state_d = F_ACTIVE;
        end else if (rise_det) begin
          fcnt_d = fcnt_q - 8'd1;
        end
      end
      F_ACTIVE: begin
        if (!FaultEn) begin
          state_d = F_OFF;
        end
      end
      default: state_d = F_OFF;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      gate_q     <= '0;
      q_q        <= 4'b0000;
      edge_cnt_q <= 8'd0;
      fcnt_q     <= 8'd0;
      state_q    <= F_OFF;
    end else begin
      gate_q     <= gate_d;
      q_q        <= q_d;
      edge_cnt_q <= edge_cnt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
    end
  end

  // Fault override sits after the Q register so the internal state keeps evolving.
  always_comb begin
    pins_out = {q_q[3], q_q[2], q_q[1], q_q[0], ~q_q[0]};
    if (state_q == F_ACTIVE) begin
      case (FaultPin)
        FAULT_PIN_11: pins_out[0] = FaultVal;
        FAULT_PIN_12: pins_out[1] = FaultVal;
        FAULT_PIN_13: pins_out[2] = FaultVal;
        FAULT_PIN_14: pins_out[3] = FaultVal;
        FAULT_PIN_15: pins_out[4] = FaultVal;
        default: ;
      endcase
    end
  end

  assign Pin15       = pins_out[4];
  assign Pin14       = pins_out[3];
  assign Pin13       = pins_out[2];
  assign Pin12       = pins_out[1];
  assign Pin11       = pins_out[0];
  assign FaultActive = (state_q == F_ACTIVE);
  assign EdgeCount   = edge_cnt_q;

endmodule

// File: tb/tb_chip_74195_emulator.sv
// Self-checking bench: directed pin sequences plus random vectors against a pin-level model.
module tb_chip_74195_emulator;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10;
  logic       Pin15, Pin14, Pin13, Pin12, Pin11;
  logic       FaultEn;
  logic [2:0] FaultPin;
  logic       FaultVal;
  logic [7:0] FaultDelay;
  logic       FaultActive;
  logic [7:0] EdgeCount;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  // Model state: Q as {QA,QB,QC,QD}, edge count, fault arming and rises still to wait for
  logic [3:0] m_q;
  bit         m_prev10;
  int         m_ec;
  bit         m_on;
  int         m_left;

  logic [4:0] seq_exp [3];

  chip_74195_emulator #(.SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5),
    .Pin6(Pin6), .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10),
    .Pin15(Pin15), .Pin14(Pin14), .Pin13(Pin13), .Pin12(Pin12), .Pin11(Pin11),
    .FaultEn(FaultEn), .FaultPin(FaultPin), .FaultVal(FaultVal),
    .FaultDelay(FaultDelay), .FaultActive(FaultActive), .EdgeCount(EdgeCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [4:0] obs_pins();
    return {Pin15, Pin14, Pin13, Pin12, Pin11};
  endfunction

  function automatic logic [4:0] exp_pins();
    logic [4:0] e;
    e = {m_q, ~m_q[0]};
    if (m_on && m_left == 0 && FaultPin < 3'd5) e[FaultPin] = FaultVal;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic model_reset();
    m_q = 4'b0000; m_ec = 0; m_on = 1'b0; m_left = 0; m_prev10 = Pin10;
  endtask

  task automatic model_step();
    bit   rise;
    logic nqa;
    rise = Pin10 && !m_prev10;
    m_prev10 = Pin10;
    if (rise) m_ec = (m_ec + 1) % 256;
    if (!Pin1) m_q = 4'b0000;
    else if (rise) begin
      if (!Pin9) m_q = {Pin4, Pin5, Pin6, Pin7};
      else begin
        if (Pin2 == Pin3) nqa = Pin2;       // 00 clears, 11 sets
        else if (Pin2) nqa = ~m_q[3];       // 10 toggles
        else nqa = m_q[3];                  // 01 holds
        m_q = {nqa, m_q[3:1]};
      end
    end
    if (!FaultEn) m_on = 1'b0;
    else begin
      if (!m_on) begin m_on = 1'b1; m_left = FaultDelay; end
      if (rise && m_left > 0) m_left--;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pins"}, 32'(obs_pins()), 32'(exp_pins()));
    check({tag, "_ec"}, 32'(EdgeCount), 32'(m_ec));
    check({tag, "_fa"}, 32'(FaultActive), 32'(m_on && m_left == 0));
  endtask

  task automatic step(input int n, input string tag);
    wait_cyc(n);
    model_step();
    check_all(tag);
  endtask

  task automatic set_data(input logic [3:0] abcd);
    {Pin4, Pin5, Pin6, Pin7} = abcd;
  endtask

  initial begin
    Reset = 1'b1; FaultEn = 1'b0; FaultPin = 3'd7; FaultVal = 1'b0; FaultDelay = 8'd0;
    Pin1 = 1'b0; Pin2 = 1'b0; Pin3 = 1'b0; Pin9 = 1'b0; Pin10 = 1'b1;
    set_data(4'b0000);
    wait_cyc(3);
    model_reset();
    check_all("reset");
    check("reset_pins_const", 32'(obs_pins()), 32'h01);

    // Chip CLK held high across reset release must not count as an edge
    Reset = 1'b0;
    step(8, "clk_high_release");
    check("clk_high_ec_const", 32'(EdgeCount), 32'd0);
    Pin10 = 1'b0;
    step(5, "clk_low");

    // Parallel load of 1010 with exact latency
    Pin1 = 1'b1; Pin9 = 1'b0; set_data(4'b1010);
    step(5, "load_setup");
    Pin10 = 1'b1;
    wait_cyc(2);
    check("load_early_pins", 32'(obs_pins()), 32'(exp_pins()));
    wait_cyc(1);
    model_step();
    check_all("load");
    check("load_pins_const", 32'(obs_pins()), 32'h15);
    check("load_ec_const", 32'(EdgeCount), 32'd1);
    Pin10 = 1'b0;
    step(5, "load_lo");

    // Shift with J=1, K_n=0: QA toggles while the rest shift
    seq_exp[0] = 5'b01010; seq_exp[1] = 5'b10101; seq_exp[2] = 5'b01010;
    Pin9 = 1'b1; Pin2 = 1'b1; Pin3 = 1'b0;
    step(5, "shift_setup");
    for (int i = 0; i < 3; i++) begin
      Pin10 = 1'b1;
      step(5, "shift");
      check("shift_pins_const", 32'(obs_pins()), 32'(seq_exp[i]));
      Pin10 = 1'b0;
      step(5, "shift_lo");
    end

    // Clear held low masks loads but edges still count
    Pin1 = 1'b0; Pin9 = 1'b0; set_data(4'b1111);
    step(5, "clr_setup");
    for (int i = 0; i < 2; i++) begin
      Pin10 = 1'b1; step(5, "clr_hi");
      Pin10 = 1'b0; step(5, "clr_lo");
    end
    check("clr_pins_const", 32'(obs_pins()), 32'h01);
    check("clr_ec_const", 32'(EdgeCount), 32'd6);

    // Fault on Pin15 stuck at 0 after two edges
    Pin1 = 1'b1; FaultEn = 1'b1; FaultPin = 3'd4; FaultVal = 1'b0; FaultDelay = 8'd2;
    step(5, "f_arm");
    Pin10 = 1'b1; step(5, "f_edge1");
    check("f_edge1_fa_const", 32'(FaultActive), 32'd0);
    check("f_edge1_pins_const", 32'(obs_pins()), 32'h1E);
    Pin10 = 1'b0; step(5, "f_edge1_lo");
    Pin10 = 1'b1; step(5, "f_edge2");
    check("f_edge2_fa_const", 32'(FaultActive), 32'd1);
    check("f_edge2_pins_const", 32'(obs_pins()), 32'h0E);
    FaultEn = 1'b0;
    step(1, "f_drop");
    check("f_drop_pins_const", 32'(obs_pins()), 32'h1E);

    // Zero-delay fault, then reset with the fault still enabled
    FaultEn = 1'b1; FaultDelay = 8'd0; FaultPin = 3'd0; FaultVal = 1'b1;
    step(5, "f0_active");
    check("f0_pins_const", 32'(obs_pins()), 32'h1F);
    Reset = 1'b1;
    wait_cyc(1);
    model_reset();
    check_all("mid_reset");
    check("mid_reset_pins_const", 32'(obs_pins()), 32'h01);
    check("mid_reset_fa_const", 32'(FaultActive), 32'd0);
    FaultEn = 1'b0; Reset = 1'b0;
    step(8, "post_reset");
    Pin10 = 1'b0;
    step(5, "post_reset_lo");

    // 256 edges wrap the counter
    for (int i = 1; i <= 256; i++) begin
      Pin10 = 1'b1; wait_cyc(4); model_step();
      if (i == 255) check("wrap_255", 32'(EdgeCount), 32'd255);
      Pin10 = 1'b0; wait_cyc(4); model_step();
    end
    check("wrap_0", 32'(EdgeCount), 32'd0);
    check_all("wrap");

    // Random pin vectors with occasional resets
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        Reset = 1'b1; FaultEn = 1'b0;
        wait_cyc(1);
        model_reset();
        check_all("rnd_reset");
        Reset = 1'b0;
        step(5, "rnd_release");
      end
      Pin1 = ($urandom_range(0, 7) != 0);
      Pin2 = 1'($urandom); Pin3 = 1'($urandom); Pin9 = 1'($urandom);
      Pin10 = 1'($urandom);
      set_data(4'($urandom));
      FaultEn = ($urandom_range(0, 3) != 0);
      FaultPin = 3'($urandom); FaultVal = 1'($urandom);
      FaultDelay = 8'($urandom_range(0, 4));
      step(5, "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
